// File: rtl/alu_pipe_acc_pkg.sv
// Shared op encodings and result-width derivation for the pipelined ALU/accumulator.
package alu_pipe_acc_pkg;

    typedef enum logic [2:0] {
        OP_AVG  = 3'b000,
        OP_DBL  = 3'b001,
        OP_HXY  = 3'b010,
        OP_XHY  = 3'b011,
        OP_NAND = 3'b100,
        OP_NOTX = 3'b101,
        OP_NOR  = 3'b110,
        OP_XOR  = 3'b111
    } op_e;

    localparam int OP_W = 3;

    // Result carries two guard bits over the operand width.
    function automatic int res_w(input int n);
        return n + 2;
    endfunction

endpackage

// File: rtl/alu_pipe_acc_core_comb.sv
// Combinational ALU: W-bit signed operands A, B -> wrapped W-bit result plus overflow flag.
module alu_core_comb
    import alu_pipe_acc_pkg::*;
#(
    parameter int W = 6
) (
    input  logic signed [W-1:0]    a,
    input  logic signed [W-1:0]    b,
    input  logic        [OP_W-1:0] op,
    output logic signed [W-1:0]    res,
    output logic                   ovf
);

    localparam int WF = W + 2;

    logic signed [WF-1:0] af;
    logic signed [WF-1:0] bf;
    logic signed [WF-1:0] full;
    logic                 arith;

    // Representable in W bits iff the top three bits are a pure sign extension.
    function automatic logic fits_w(input logic signed [WF-1:0] v);
        return (v[WF-1:W-1] == '0) || (v[WF-1:W-1] == '1);
    endfunction

    assign af = {{2{a[W-1]}}, a};
    assign bf = {{2{b[W-1]}}, b};

    always_comb begin
        full  = '0;
        arith = 1'b1;
        case (op_e'(op))
            OP_AVG:  full = (af + bf) >>> 1;
            OP_DBL:  full = (af + bf) <<< 1;
            OP_HXY:  full = (af >>> 1) + bf;
            OP_XHY:  full = af - (bf >>> 1);
            OP_NAND: begin full = ~(af & bf); arith = 1'b0; end
            OP_NOTX: begin full = ~af;        arith = 1'b0; end
            OP_NOR:  begin full = ~(af | bf); arith = 1'b0; end
            OP_XOR:  begin full = af ^ bf;    arith = 1'b0; end
        endcase
        res = full[W-1:0];
        ovf = arith && !fits_w(full);
    end

endmodule

// File: rtl/alu_pipe_acc.sv
// Two-stage valid/ready ALU pipeline with a result accumulator usable as operand A.
module alu_pipe_acc
    import alu_pipe_acc_pkg::*;
#(
    parameter int N = 4,
    parameter int W = res_w(N)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic signed [N-1:0]    x,
    input  logic signed [N-1:0]    y,
    input  logic        [OP_W-1:0] op,
    input  logic                   acc_en,
    input  logic                   acc_clr,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic signed [W-1:0]    o,
    output logic                   ovf
);

    logic                   vld_p1;
    logic signed [W-1:0]    x_p1;
    logic signed [N-1:0]    y_p1;
    logic        [OP_W-1:0] op_p1;
    logic                   acc_en_p1;
    logic                   acc_clr_p1;

    logic                   vld_p2;
    logic signed [W-1:0]    o_p2;
    logic                   ovf_p2;
    logic signed [W-1:0]    acc;

    logic                   accept;
    logic                   s2_load;
    logic signed [W-1:0]    a_op;
    logic signed [W-1:0]    b_op;
    logic signed [W-1:0]    res;
    logic                   res_ovf;

    assign in_ready = rst_n && (!vld_p1 || !vld_p2 || out_ready);
    assign accept   = in_valid && in_ready;
    assign s2_load  = vld_p1 && (!vld_p2 || out_ready);

    // Stage 1: operand capture
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_p1 <= 1'b0;
        end else if (accept) begin
            vld_p1 <= 1'b1;
        end else if (s2_load) begin
            vld_p1 <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            x_p1       <= {{(W-N){x[N-1]}}, x};
            y_p1       <= y;
            op_p1      <= op;
            acc_en_p1  <= acc_en;
            acc_clr_p1 <= acc_clr;
        end
    end

    // Accumulator is read at the S1->S2 transfer, so chained beats see the previous result.
    assign a_op = acc_en_p1 ? (acc_clr_p1 ? '0 : acc) : x_p1;
    assign b_op = {{(W-N){y_p1[N-1]}}, y_p1};

    alu_core_comb #(
        .W (W)
    ) u_core (
        .a   (a_op),
        .b   (b_op),
        .op  (op_p1),
        .res (res),
        .ovf (res_ovf)
    );

    // Stage 2: result and accumulator
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_p2 <= 1'b0;
            o_p2   <= '0;
            ovf_p2 <= 1'b0;
            acc    <= '0;
        end else if (s2_load) begin
            vld_p2 <= 1'b1;
            o_p2   <= res;
            ovf_p2 <= res_ovf;
            acc    <= res;
        end else if (out_ready) begin
            vld_p2 <= 1'b0;
        end
    end

    assign out_valid = vld_p2;
    assign o         = o_p2;
    assign ovf       = ovf_p2;

endmodule

// File: tb/tb_alu_pipe_acc.sv
// Bench for alu_pipe_acc: directed vector table, hand-written handshake/reset sequences, random traffic vs reference model.
module tb_alu_pipe_acc;

    localparam int N = 4;
    localparam int W = 6;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                in_valid;
    logic                in_ready;
    logic signed [N-1:0] x;
    logic signed [N-1:0] y;
    logic        [2:0]   op;
    logic                acc_en;
    logic                acc_clr;
    logic                out_valid;
    logic                out_ready;
    logic signed [W-1:0] o;
    logic                ovf;

    always #5 clk = ~clk;

    alu_pipe_acc #(.N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .y         (y),
        .op        (op),
        .acc_en    (acc_en),
        .acc_clr   (acc_clr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .o         (o),
        .ovf       (ovf)
    );

    int n_cmp = 0;
    int n_bad = 0;

    int exp_o_q[$];
    bit exp_ovf_q[$];
    int obs_o_q[$];
    bit obs_ovf_q[$];
    int model_acc = 0;
    bit hold_prev = 1'b0;
    int prev_o;
    bit prev_ovf;

    typedef struct {
        int x;
        int y;
        int op;
        bit en;
        bit clr;
        int eo;
        bit eovf;
    } vec_t;

    localparam int NT = 16;
    vec_t tbl[NT];

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference model: exact integer arithmetic, then wrap to W bits.
    function automatic int floor_half(input int v);
        if (v >= 0) return v / 2;
        return -((1 - v) / 2);
    endfunction

    function automatic int ref_full(input int a, input int b, input int opv);
        case (opv)
            0:       return floor_half(a + b);
            1:       return (a + b) * 2;
            2:       return floor_half(a) + b;
            3:       return a - floor_half(b);
            4:       return ~(a & b);
            5:       return ~a;
            6:       return ~(a | b);
            default: return a ^ b;
        endcase
    endfunction

    function automatic int wrapw(input int v);
        int m;
        m = v & ((1 << W) - 1);
        return (m >= (1 << (W - 1))) ? m - (1 << W) : m;
    endfunction

    // Monitor/scoreboard: beats are in order, so each accepted beat's acc is the previous beat's result.
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("in_ready_during_reset", in_ready, 0);
            exp_o_q.delete();
            exp_ovf_q.delete();
            model_acc = 0;
            hold_prev = 1'b0;
        end else begin
            if (hold_prev) begin
                chk("stall_hold_valid", out_valid, 1);
                chk("stall_hold_o", o, prev_o);
                chk("stall_hold_ovf", ovf, prev_ovf);
            end
            if (out_valid && out_ready) begin
                obs_o_q.push_back(o);
                obs_ovf_q.push_back(ovf);
                if (exp_o_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_beat: got o=%0d, expected no output", o);
                end else begin
                    chk("model_o", o, exp_o_q.pop_front());
                    chk("model_ovf", ovf, exp_ovf_q.pop_front());
                end
            end
            if (in_valid && in_ready) begin
                int a, b, f, r, xi;
                xi = x;
                b  = y;
                a  = acc_en ? (acc_clr ? 0 : model_acc) : xi;
                f  = ref_full(a, b, int'(op));
                r  = wrapw(f);
                exp_o_q.push_back(r);
                exp_ovf_q.push_back((op < 3'd4) && (f < -(1 << (W - 1)) || f > (1 << (W - 1)) - 1));
                model_acc = r;
            end
            hold_prev = out_valid && !out_ready;
            prev_o    = o;
            prev_ovf  = ovf;
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic send(input int xv, input int yv, input int opv, input bit en, input bit clr);
        bit done;
        done     = 1'b0;
        in_valid = 1'b1;
        x        = N'(xv);
        y        = N'(yv);
        op       = 3'(opv);
        acc_en   = en;
        acc_clr  = clr;
        for (int t = 0; t < 40 && !done; t++) begin
            @(negedge clk);
            done = in_ready;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!done) begin
            n_cmp++;
            n_bad++;
            $display("FAIL send_timeout: in_ready stayed 0, expected 1");
        end
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; x = '0; y = '0; op = '0;
        acc_en = 1'b0; acc_clr = 1'b0; out_ready = 1'b1;

        tbl[0]  = '{7, 7, 1, 0, 0, 28, 0};
        tbl[1]  = '{0, 7, 1, 1, 0, 6, 1};
        tbl[2]  = '{-3, 5, 3, 0, 0, -5, 0};
        tbl[3]  = '{-3, 1, 2, 0, 0, -1, 0};
        tbl[4]  = '{5, 3, 7, 0, 0, 6, 0};
        tbl[5]  = '{0, -8, 5, 1, 1, -1, 0};
        tbl[6]  = '{0, 2, 0, 1, 0, 0, 0};
        tbl[7]  = '{-8, -8, 1, 0, 0, -32, 0};
        tbl[8]  = '{-8, -8, 0, 0, 0, -8, 0};
        tbl[9]  = '{7, -8, 4, 0, 0, -1, 0};
        tbl[10] = '{5, -6, 6, 0, 0, 0, 0};
        tbl[11] = '{0, 7, 1, 1, 0, 14, 0};
        tbl[12] = '{7, -8, 3, 0, 0, 11, 0};
        tbl[13] = '{0, 7, 1, 1, 0, -28, 1};
        tbl[14] = '{0, 7, 1, 1, 0, 22, 1};
        tbl[15] = '{3, 1, 0, 0, 1, 2, 0};

        // Reset state
        cycles(2);
        @(negedge clk);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_o", o, 0);
        chk("reset_ovf", ovf, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // First-beat latency
        send(7, 7, 1, 0, 0);
        @(negedge clk);
        chk("latency_edge1_valid", out_valid, 0);
        @(negedge clk);
        chk("latency_edge2_valid", out_valid, 1);
        chk("latency_o", o, 28);
        chk("latency_ovf", ovf, 0);
        cycles(3);

        // Vector table, streamed back-to-back
        do_reset();
        obs_o_q.delete();
        obs_ovf_q.delete();
        for (int i = 0; i < NT; i++)
            send(tbl[i].x, tbl[i].y, tbl[i].op, tbl[i].en, tbl[i].clr);
        cycles(5);
        chk("table_beat_count", obs_o_q.size(), NT);
        for (int i = 0; i < NT && i < obs_o_q.size(); i++) begin
            chk($sformatf("table_o[%0d]", i), obs_o_q[i], tbl[i].eo);
            chk($sformatf("table_ovf[%0d]", i), obs_ovf_q[i], tbl[i].eovf);
        end

        // Backpressure: two beats fit, third waits, all three drain in order
        begin
            int bx[3] = '{1, -4, 6};
            int by[3] = '{2, 3, -5};
            int bo[3] = '{0, 1, 7};
            int be[3] = '{1, -2, -3};
            int k;
            do_reset();
            obs_o_q.delete();
            obs_ovf_q.delete();
            out_ready = 1'b0;
            k = 0;
            for (int c = 0; c < 45 && k < 3; c++) begin
                bit rdy;
                if (c == 5) out_ready = 1'b1;
                in_valid = 1'b1;
                x = N'(bx[k]); y = N'(by[k]); op = 3'(bo[k]);
                acc_en = 1'b0; acc_clr = 1'b0;
                @(negedge clk);
                rdy = in_ready;
                if (c < 5) chk($sformatf("stall_in_ready_c%0d", c), rdy, (c < 2) ? 1 : 0);
                @(posedge clk);
                #1;
                if (rdy) k++;
            end
            in_valid = 1'b0;
            chk("stall_all_accepted", k, 3);
            cycles(5);
            chk("stall_beat_count", obs_o_q.size(), 3);
            for (int i = 0; i < 3 && i < obs_o_q.size(); i++)
                chk($sformatf("stall_o[%0d]", i), obs_o_q[i], be[i]);
        end

        // Reset with both stages full discards everything and clears acc
        out_ready = 1'b0;
        send(1, 1, 0, 0, 0);
        send(2, 2, 0, 0, 0);
        do_reset();
        @(negedge clk);
        chk("midreset_out_valid", out_valid, 0);
        chk("midreset_o", o, 0);
        chk("midreset_ovf", ovf, 0);
        out_ready = 1'b1;
        obs_o_q.delete();
        obs_ovf_q.delete();
        @(posedge clk);
        #1;
        send(0, 2, 0, 1, 0);
        cycles(4);
        chk("midreset_beat_count", obs_o_q.size(), 1);
        if (obs_o_q.size() > 0) chk("midreset_acc_o", obs_o_q[0], 1);

        // Random traffic with occasional resets
        for (int i = 0; i < 800; i++) begin
            rst_n     = ($urandom_range(0, 99) != 0);
            in_valid  = $urandom_range(0, 1);
            x         = N'($urandom);
            y         = N'($urandom);
            op        = 3'($urandom);
            acc_en    = $urandom_range(0, 1);
            acc_clr   = ($urandom_range(0, 3) == 0);
            out_ready = ($urandom_range(0, 3) != 0);
            cycles(1);
        end
        rst_n = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        cycles(6);
        chk("drain_pending_beats", exp_o_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
